// File: rtl/udma_jtag_fifo_ctrl.sv
// JTAG FIFO transfer controller: bounded RX/TX byte-counted transfers
// between uDMA channel streams and the 32-bit JTAG FIFO streams.

module udma_jtag_fifo_ctrl_ch #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [TRANS_SIZE-1:0] size_i,
  input  logic [1:0]            ds_i,
  input  logic [31:0]           src_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  output logic [31:0]           dst_data_o,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [1:0]            ds_o,
  output logic                  busy_o,
  output logic [TRANS_SIZE-1:0] left_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e                r_state;
  logic [TRANS_SIZE-1:0] r_left;
  logic [1:0]            r_ds;
  logic [31:0]           r_buf;
  logic                  r_bvalid;
  logic                  r_done;

  logic [TRANS_SIZE-1:0] w_beat;
  logic [31:0]           w_mask;
  logic                  w_acc;
  logic                  w_hs;
  logic                  w_last;

  always_comb begin
    w_beat = TRANS_SIZE'(4);
    w_mask = 32'hFFFF_FFFF;
    case (r_ds)
      2'b00: begin
        w_beat = TRANS_SIZE'(1);
        w_mask = 32'h0000_00FF;
      end
      2'b01: begin
        w_beat = TRANS_SIZE'(2);
        w_mask = 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

  assign src_ready_o = (r_state == ST_RUN) & (~r_bvalid | dst_ready_i);
  assign w_acc       = src_ready_o & src_valid_i;
  assign w_hs        = r_bvalid & dst_ready_i;
  // A short final beat consumes whatever is left, so no underflow.
  assign w_last      = (r_left <= w_beat);

  assign dst_data_o  = r_buf;
  assign dst_valid_o = r_bvalid;
  assign ds_o        = r_ds;
  assign busy_o      = (r_state != ST_IDLE);
  assign left_o      = r_left;
  assign done_o      = r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_left   <= '0;
      r_ds     <= '0;
      r_buf    <= '0;
      r_bvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (clr_i) begin
        r_state  <= ST_IDLE;
        r_bvalid <= 1'b0;
        r_left   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (en_i) begin
              r_ds   <= ds_i;
              r_left <= size_i;
              if (size_i == '0) r_done  <= 1'b1;
              else              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_acc) begin
              r_buf    <= src_data_i & w_mask;
              r_bvalid <= 1'b1;
              r_left   <= w_last ? '0 : r_left - w_beat;
              if (w_last) r_state <= ST_DRAIN;
            end else if (w_hs) begin
              r_bvalid <= 1'b0;
            end
          end
          ST_DRAIN: begin
            if (w_hs) begin
              r_bvalid <= 1'b0;
              r_state  <= ST_IDLE;
              r_done   <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

module udma_jtag_fifo_ctrl #(
  parameter int TRANS_SIZE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_clr_i,
  input  logic                  cfg_rx_en_i,
  input  logic [TRANS_SIZE-1:0] cfg_rx_size_i,
  input  logic [1:0]            cfg_rx_datasize_i,
  input  logic                  cfg_tx_en_i,
  input  logic [TRANS_SIZE-1:0] cfg_tx_size_i,
  input  logic [1:0]            cfg_tx_datasize_i,
  input  logic [31:0]           fifo_rx_data_i,
  input  logic                  fifo_rx_valid_i,
  output logic                  fifo_rx_ready_o,
  output logic [31:0]           udma_rx_data_o,
  output logic [1:0]            udma_rx_datasize_o,
  output logic                  udma_rx_valid_o,
  input  logic                  udma_rx_ready_i,
  input  logic [31:0]           udma_tx_data_i,
  input  logic                  udma_tx_valid_i,
  output logic                  udma_tx_ready_o,
  output logic [1:0]            udma_tx_datasize_o,
  output logic [31:0]           fifo_tx_data_o,
  output logic                  fifo_tx_valid_o,
  input  logic                  fifo_tx_ready_i,
  output logic                  rx_busy_o,
  output logic                  tx_busy_o,
  output logic [TRANS_SIZE-1:0] rx_bytes_left_o,
  output logic [TRANS_SIZE-1:0] tx_bytes_left_o,
  output logic                  rx_done_evt_o,
  output logic                  tx_done_evt_o
);

  udma_jtag_fifo_ctrl_ch #(.TRANS_SIZE(TRANS_SIZE)) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (cfg_clr_i),
    .en_i        (cfg_rx_en_i),
    .size_i      (cfg_rx_size_i),
    .ds_i        (cfg_rx_datasize_i),
    .src_data_i  (fifo_rx_data_i),
    .src_valid_i (fifo_rx_valid_i),
    .src_ready_o (fifo_rx_ready_o),
    .dst_data_o  (udma_rx_data_o),
    .dst_valid_o (udma_rx_valid_o),
    .dst_ready_i (udma_rx_ready_i),
    .ds_o        (udma_rx_datasize_o),
    .busy_o      (rx_busy_o),
    .left_o      (rx_bytes_left_o),
    .done_o      (rx_done_evt_o)
  );

  udma_jtag_fifo_ctrl_ch #(.TRANS_SIZE(TRANS_SIZE)) u_tx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (cfg_clr_i),
    .en_i        (cfg_tx_en_i),
    .size_i      (cfg_tx_size_i),
    .ds_i        (cfg_tx_datasize_i),
    .src_data_i  (udma_tx_data_i),
    .src_valid_i (udma_tx_valid_i),
    .src_ready_o (udma_tx_ready_o),
    .dst_data_o  (fifo_tx_data_o),
    .dst_valid_o (fifo_tx_valid_o),
    .dst_ready_i (fifo_tx_ready_i),
    .ds_o        (udma_tx_datasize_o),
    .busy_o      (tx_busy_o),
    .left_o      (tx_bytes_left_o),
    .done_o      (tx_done_evt_o)
  );

endmodule

// File: tb/tb_udma_jtag_fifo_ctrl.sv
// Bench for udma_jtag_fifo_ctrl: queue-based transfer model checked
// every cycle, plus directed scenarios with literal expectations.

module tb_udma_jtag_fifo_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_clr_i = 1'b0;
  logic        cfg_rx_en_i = 1'b0;
  logic [15:0] cfg_rx_size_i = '0;
  logic [1:0]  cfg_rx_datasize_i = '0;
  logic        cfg_tx_en_i = 1'b0;
  logic [15:0] cfg_tx_size_i = '0;
  logic [1:0]  cfg_tx_datasize_i = '0;
  logic [31:0] fifo_rx_data_i = '0;
  logic        fifo_rx_valid_i = 1'b0;
  logic        fifo_rx_ready_o;
  logic [31:0] udma_rx_data_o;
  logic [1:0]  udma_rx_datasize_o;
  logic        udma_rx_valid_o;
  logic        udma_rx_ready_i = 1'b0;
  logic [31:0] udma_tx_data_i = '0;
  logic        udma_tx_valid_i = 1'b0;
  logic        udma_tx_ready_o;
  logic [1:0]  udma_tx_datasize_o;
  logic [31:0] fifo_tx_data_o;
  logic        fifo_tx_valid_o;
  logic        fifo_tx_ready_i = 1'b0;
  logic        rx_busy_o;
  logic        tx_busy_o;
  logic [15:0] rx_bytes_left_o;
  logic [15:0] tx_bytes_left_o;
  logic        rx_done_evt_o;
  logic        tx_done_evt_o;

  always #5 clk_i = ~clk_i;

  udma_jtag_fifo_ctrl #(.TRANS_SIZE(16)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cfg_clr_i          (cfg_clr_i),
    .cfg_rx_en_i        (cfg_rx_en_i),
    .cfg_rx_size_i      (cfg_rx_size_i),
    .cfg_rx_datasize_i  (cfg_rx_datasize_i),
    .cfg_tx_en_i        (cfg_tx_en_i),
    .cfg_tx_size_i      (cfg_tx_size_i),
    .cfg_tx_datasize_i  (cfg_tx_datasize_i),
    .fifo_rx_data_i     (fifo_rx_data_i),
    .fifo_rx_valid_i    (fifo_rx_valid_i),
    .fifo_rx_ready_o    (fifo_rx_ready_o),
    .udma_rx_data_o     (udma_rx_data_o),
    .udma_rx_datasize_o (udma_rx_datasize_o),
    .udma_rx_valid_o    (udma_rx_valid_o),
    .udma_rx_ready_i    (udma_rx_ready_i),
    .udma_tx_data_i     (udma_tx_data_i),
    .udma_tx_valid_i    (udma_tx_valid_i),
    .udma_tx_ready_o    (udma_tx_ready_o),
    .udma_tx_datasize_o (udma_tx_datasize_o),
    .fifo_tx_data_o     (fifo_tx_data_o),
    .fifo_tx_valid_o    (fifo_tx_valid_o),
    .fifo_tx_ready_i    (fifo_tx_ready_i),
    .rx_busy_o          (rx_busy_o),
    .tx_busy_o          (tx_busy_o),
    .rx_bytes_left_o    (rx_bytes_left_o),
    .tx_bytes_left_o    (tx_bytes_left_o),
    .rx_done_evt_o      (rx_done_evt_o),
    .tx_done_evt_o      (tx_done_evt_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // source streams and observation logs
  logic [31:0] rxs[$];
  logic [31:0] txs[$];
  logic [31:0] rx_got[$];
  logic [31:0] tx_got[$];
  int          rx_hs[$];
  int          rx_pops = 0;
  int          tx_pops = 0;
  int          rx_done_n = 0;
  int          tx_done_n = 0;
  int          cyc = 0;

  // model: expected output words, busy, bytes left, pending done
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  bit          m_busy[2];
  bit          m_all[2];
  bit          m_done[2];
  logic [15:0] m_left[2];
  logic [1:0]  m_ds[2];

  function automatic logic [31:0] mask_of(input logic [31:0] d,
                                          input logic [1:0] ds);
    if (ds == 2'b00) return {24'h0, d[7:0]};
    if (ds == 2'b01) return {16'h0, d[15:0]};
    return d;
  endfunction

  function automatic logic [15:0] beat_of(input logic [1:0] ds);
    if (ds == 2'b00) return 16'd1;
    if (ds == 2'b01) return 16'd2;
    return 16'd4;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_busy[c] = 0;
      m_all[c]  = 0;
      m_done[c] = 0;
      m_left[c] = '0;
      m_ds[c]   = '0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  task automatic step(input int ch, input logic busy,
                      input logic [15:0] left, input logic done,
                      input logic vld, input logic [31:0] dat,
                      input logic srdy, input logic [1:0] dso,
                      input logic sval, input logic [31:0] sdat,
                      input logic drdy, input logic en,
                      input logic [15:0] size, input logic [1:0] ds);
    string       p;
    int          qn;
    bit          erdy;
    bit          nd;
    bit          was_busy;
    logic [15:0] bt;
    logic [15:0] dec;
    p    = (ch == 1) ? "tx" : "rx";
    qn   = (ch == 1) ? mq1.size() : mq0.size();
    erdy = m_busy[ch] && !m_all[ch] && (qn == 0 || drdy);
    chk({p, "_busy"}, 32'(busy), 32'(m_busy[ch]));
    chk({p, "_bytes_left"}, 32'(left), 32'(m_left[ch]));
    chk({p, "_done_evt"}, 32'(done), 32'(m_done[ch]));
    chk({p, "_dst_valid"}, 32'(vld), 32'(qn != 0));
    chk({p, "_src_ready"}, 32'(srdy), 32'(erdy));
    chk({p, "_datasize"}, 32'(dso), 32'(m_ds[ch]));
    if (qn != 0)
      chk({p, "_dst_data"}, dat, (ch == 1) ? mq1[0] : mq0[0]);
    nd = 0;
    if (cfg_clr_i) begin
      m_busy[ch] = 0;
      m_all[ch]  = 0;
      m_left[ch] = '0;
      if (ch == 1) mq1.delete(); else mq0.delete();
    end else begin
      was_busy = m_busy[ch];
      if (qn != 0 && drdy) begin
        if (ch == 1) void'(mq1.pop_front());
        else         void'(mq0.pop_front());
        qn--;
        if (m_all[ch] && qn == 0) begin
          m_busy[ch] = 0;
          m_all[ch]  = 0;
          nd = 1;
        end
      end
      if (erdy && sval) begin
        if (ch == 1) mq1.push_back(mask_of(sdat, m_ds[ch]));
        else         mq0.push_back(mask_of(sdat, m_ds[ch]));
        bt  = beat_of(m_ds[ch]);
        dec = (bt < m_left[ch]) ? bt : m_left[ch];
        m_left[ch] = m_left[ch] - dec;
        if (m_left[ch] == 0) m_all[ch] = 1;
      end
      if (!was_busy && en) begin
        m_ds[ch]   = ds;
        m_left[ch] = size;
        if (size == 0) nd = 1;
        else begin
          m_busy[ch] = 1;
          m_all[ch]  = 0;
        end
      end
    end
    m_done[ch] = nd;
  endtask

  always @(negedge clk_i) begin
    cyc++;
    if (rst_i) begin
      model_reset();
    end else begin
      if (rx_done_evt_o) rx_done_n++;
      if (tx_done_evt_o) tx_done_n++;
      if (udma_rx_valid_o && udma_rx_ready_i) begin
        rx_got.push_back(udma_rx_data_o);
        rx_hs.push_back(cyc);
      end
      if (fifo_tx_valid_o && fifo_tx_ready_i)
        tx_got.push_back(fifo_tx_data_o);
      step(0, rx_busy_o, rx_bytes_left_o, rx_done_evt_o,
           udma_rx_valid_o, udma_rx_data_o, fifo_rx_ready_o,
           udma_rx_datasize_o, fifo_rx_valid_i, fifo_rx_data_i,
           udma_rx_ready_i, cfg_rx_en_i, cfg_rx_size_i,
           cfg_rx_datasize_i);
      step(1, tx_busy_o, tx_bytes_left_o, tx_done_evt_o,
           fifo_tx_valid_o, fifo_tx_data_o, udma_tx_ready_o,
           udma_tx_datasize_o, udma_tx_valid_i, udma_tx_data_i,
           fifo_tx_ready_i, cfg_tx_en_i, cfg_tx_size_i,
           cfg_tx_datasize_i);
    end
  end

  // source drivers: present queue head, pop on handshake
  initial begin : drv
    bit rt;
    bit tt;
    forever begin
      @(negedge clk_i);
      rt = fifo_rx_valid_i & fifo_rx_ready_o;
      tt = udma_tx_valid_i & udma_tx_ready_o;
      @(posedge clk_i);
      #1;
      if (rt && rxs.size() != 0) begin
        void'(rxs.pop_front());
        rx_pops++;
      end
      if (tt && txs.size() != 0) begin
        void'(txs.pop_front());
        tx_pops++;
      end
      fifo_rx_valid_i = (rxs.size() != 0);
      fifo_rx_data_i  = (rxs.size() != 0) ? rxs[0] : 32'h0;
      udma_tx_valid_i = (txs.size() != 0);
      udma_tx_data_i  = (txs.size() != 0) ? txs[0] : 32'h0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_done(input int ch, input int base, input string nm);
    int i;
    i = 0;
    while (((ch == 1) ? tx_done_n : rx_done_n) == base && i < 40) begin
      tick();
      i++;
    end
    chk({nm, "_done_seen"},
        32'(((ch == 1) ? tx_done_n : rx_done_n) > base), 32'd1);
  endtask

  int base;
  int p0;

  initial begin
    model_reset();
    tick(2);
    chk("rst_rx_busy", 32'(rx_busy_o), 0);
    chk("rst_tx_busy", 32'(tx_busy_o), 0);
    chk("rst_left", {rx_bytes_left_o, tx_bytes_left_o}, 0);
    chk("rst_valids", {28'h0, udma_rx_valid_o, fifo_tx_valid_o,
        fifo_rx_ready_o, udma_tx_ready_o}, 0);
    chk("rst_rx_data", udma_rx_data_o, 0);
    chk("rst_tx_data", fifo_tx_data_o, 0);
    chk("rst_misc", {26'h0, udma_rx_datasize_o, udma_tx_datasize_o,
        rx_done_evt_o, tx_done_evt_o}, 0);
    rst_i = 1'b0;
    tick(2);

    // 1: RX 8 bytes, 4-byte beats, full throughput
    udma_rx_ready_i = 1'b1;
    rxs.push_back(32'h1122_3344);
    rxs.push_back(32'h5566_7788);
    rx_got.delete();
    rx_hs.delete();
    base = rx_done_n;
    cfg_rx_size_i = 16'd8;
    cfg_rx_datasize_i = 2'b10;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    chk("t1_left_start", 32'(rx_bytes_left_o), 32'd8);
    wait_done(0, base, "t1");
    tick(2);
    chk("t1_beats", rx_got.size(), 2);
    if (rx_got.size() == 2 && rx_hs.size() == 2) begin
      chk("t1_w0", rx_got[0], 32'h1122_3344);
      chk("t1_w1", rx_got[1], 32'h5566_7788);
      chk("t1_back_to_back", rx_hs[1] - rx_hs[0], 1);
    end
    chk("t1_done_once", rx_done_n - base, 1);

    // 2: RX 3 bytes, 2-byte beats, partial last beat
    rx_got.delete();
    repeat (3) rxs.push_back(32'hDEAD_BEEF);
    base = rx_done_n;
    cfg_rx_size_i = 16'd3;
    cfg_rx_datasize_i = 2'b01;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    wait_done(0, base, "t2");
    tick(2);
    chk("t2_beats", rx_got.size(), 2);
    if (rx_got.size() == 2) begin
      chk("t2_w0", rx_got[0], 32'h0000_BEEF);
      chk("t2_w1", rx_got[1], 32'h0000_BEEF);
    end
    chk("t2_third_unpopped", rxs.size(), 1);
    rxs.delete();
    tick(2);

    // 3: TX 12 bytes with a 5-cycle FIFO stall
    fifo_tx_ready_i = 1'b0;
    tx_got.delete();
    txs.push_back(32'hA0A0_A0A0);
    txs.push_back(32'hB1B1_B1B1);
    txs.push_back(32'hC2C2_C2C2);
    base = tx_done_n;
    p0 = tx_pops;
    cfg_tx_size_i = 16'd12;
    cfg_tx_datasize_i = 2'b10;
    cfg_tx_en_i = 1'b1;
    tick();
    cfg_tx_en_i = 1'b0;
    tick(5);
    chk("t3_stall_ready", 32'(udma_tx_ready_o), 0);
    chk("t3_stall_valid", 32'(fifo_tx_valid_o), 1);
    chk("t3_stall_data", fifo_tx_data_o, 32'hA0A0_A0A0);
    chk("t3_stall_left", 32'(tx_bytes_left_o), 32'd8);
    fifo_tx_ready_i = 1'b1;
    wait_done(1, base, "t3");
    tick(2);
    chk("t3_words", tx_got.size(), 3);
    if (tx_got.size() == 3) chk("t3_w2", tx_got[2], 32'hC2C2_C2C2);
    chk("t3_pops", tx_pops - p0, 3);
    chk("t3_done_once", tx_done_n - base, 1);

    // 4: RX and TX together, 1-byte beats
    rx_got.delete();
    tx_got.delete();
    rxs = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h55AA_33CC};
    txs = '{32'h8765_4321, 32'h0FED_CBA9, 32'hAABB_CCDD, 32'h0102_0304};
    base = rx_done_n;
    p0 = tx_done_n;
    cfg_rx_size_i = 16'd4;
    cfg_tx_size_i = 16'd4;
    cfg_rx_datasize_i = 2'b00;
    cfg_tx_datasize_i = 2'b00;
    cfg_rx_en_i = 1'b1;
    cfg_tx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    cfg_tx_en_i = 1'b0;
    wait_done(0, base, "t4_rx");
    wait_done(1, p0, "t4_tx");
    tick(2);
    chk("t4_rx_words", rx_got.size(), 4);
    chk("t4_tx_words", tx_got.size(), 4);
    if (rx_got.size() == 4 && tx_got.size() == 4) begin
      chk("t4_rx_w1", rx_got[1], 32'h0000_00F0);
      chk("t4_rx_w3", rx_got[3], 32'h0000_00CC);
      chk("t4_tx_w0", tx_got[0], 32'h0000_0021);
      chk("t4_tx_w2", tx_got[2], 32'h0000_00DD);
    end

    // 5: clear after the first of four TX beats, then restart
    tx_got.delete();
    txs.push_back(32'hDEAD_BEEF);
    base = tx_done_n;
    cfg_tx_size_i = 16'd16;
    cfg_tx_datasize_i = 2'b10;
    cfg_tx_en_i = 1'b1;
    tick();
    cfg_tx_en_i = 1'b0;
    tick(2);
    chk("t5_first_beat", tx_got.size(), 1);
    cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    chk("t5_clr_busy", 32'(tx_busy_o), 0);
    chk("t5_clr_valid", 32'(fifo_tx_valid_o), 0);
    chk("t5_clr_left", 32'(tx_bytes_left_o), 0);
    tick(3);
    chk("t5_no_done", tx_done_n - base, 0);
    cfg_tx_en_i = 1'b1;
    cfg_clr_i = 1'b1;
    tick();
    cfg_tx_en_i = 1'b0;
    cfg_clr_i = 1'b0;
    chk("t5_clr_beats_en", 32'(tx_busy_o), 0);
    txs.push_back(32'hCAFE_F00D);
    cfg_tx_size_i = 16'd4;
    cfg_tx_en_i = 1'b1;
    tick();
    cfg_tx_en_i = 1'b0;
    wait_done(1, base, "t5_restart");
    tick(2);
    chk("t5_restart_word", tx_got[tx_got.size()-1], 32'hCAFE_F00D);

    // 6: zero size, en while busy, reset mid-transfer
    rx_got.delete();
    rxs.push_back(32'h1111_1111);
    base = rx_done_n;
    p0 = rx_pops;
    cfg_rx_size_i = 16'd0;
    cfg_rx_datasize_i = 2'b10;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    tick(3);
    chk("t6_zero_done", rx_done_n - base, 1);
    chk("t6_zero_nopop", rx_pops - p0, 0);
    udma_rx_ready_i = 1'b0;
    base = rx_done_n;
    cfg_rx_size_i = 16'd8;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    tick(2);
    cfg_rx_size_i = 16'd4;
    cfg_rx_datasize_i = 2'b00;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    chk("t6_en_busy_left", 32'(rx_bytes_left_o), 32'd4);
    chk("t6_en_busy_ds", 32'(udma_rx_datasize_o), 32'd2);
    rxs.push_back(32'h2222_2222);
    udma_rx_ready_i = 1'b1;
    wait_done(0, base, "t6_run");
    tick(2);
    chk("t6_words", rx_got.size(), 2);
    if (rx_got.size() == 2) chk("t6_w1", rx_got[1], 32'h2222_2222);
    udma_rx_ready_i = 1'b0;
    rxs.push_back(32'h3333_3333);
    cfg_rx_size_i = 16'd8;
    cfg_rx_datasize_i = 2'b10;
    cfg_rx_en_i = 1'b1;
    tick();
    cfg_rx_en_i = 1'b0;
    tick(2);
    chk("t6_pre_rst_valid", 32'(udma_rx_valid_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(rx_busy_o), 0);
    chk("t6_rst_left", 32'(rx_bytes_left_o), 0);
    chk("t6_rst_valid", 32'(udma_rx_valid_o), 0);
    chk("t6_rst_data", udma_rx_data_o, 0);
    chk("t6_rst_ds", 32'(udma_rx_datasize_o), 0);
    rxs.delete();
    txs.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick(3);
    chk("t6_post_rst_idle", 32'(rx_busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
